// File: rtl/ebus_xfer.sv
// EBUS transfer sequencer: runs one CONO/CONI/DATAO/DATAI against NDEV devices.
// Latency: SETUP_CYC setup + demand wait + release wait + 1 finish cycle; illegal func completes in 1 cycle.
// Backpressure: req is ignored while busy; the device side paces the bus through devXfer, bounded by TMO.
module ebus_xfer #(
    parameter int NDEV      = 8,
    parameter int DW        = 36,
    parameter int DEVW      = 7,
    parameter int SETUP_CYC = 1,
    parameter int TMO       = 255
) (
    input  logic                 clk60,
    input  logic                 CROBAR_N,
    input  logic                 req,
    input  logic [2:0]           func,
    input  logic [DEVW-1:0]      devCode,
    input  logic [DW-1:0]        wdata,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [DW-1:0]        rdata,
    output logic                 errTimeout,
    output logic                 errConflict,
    output logic                 errAbort,
    output logic                 errIllegal,
    output logic [DEVW-1:0]      ebusCS,
    output logic [2:0]           ebusFunc,
    output logic                 ebusDemand,
    output logic [DW-1:0]        ebusDataOut,
    output logic                 ebusDataOutEn,
    input  logic [NDEV-1:0]      devXfer,
    input  logic [NDEV*DW-1:0]   devData
);

    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_C    = CW'(TMO);
    localparam logic [CW-1:0] TMO_M1   = CW'(TMO - 1);
    localparam logic [3:0]    SETUP_M1 = 4'(SETUP_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_DEMAND  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [2:0]      func_q, func_d;
    logic [DEVW-1:0] dev_q, dev_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      scnt_q, scnt_d;
    logic            err_tmo_q, err_tmo_d;
    logic            err_cfl_q, err_cfl_d;
    logic            err_abt_q, err_abt_d;
    logic            err_ill_q, err_ill_d;

    logic [DW-1:0]   rd_or;
    logic            xfer_any;
    logic            xfer_multi;
    logic [CW-1:0]   cnt_inc;
    logic            on_bus;

    assign xfer_any   = |devXfer;
    // Clearing the lowest set bit leaves something only if two or more devices answered.
    assign xfer_multi = |(devXfer & (devXfer - NDEV'(1)));
    // Wait counter saturates at TMO instead of wrapping.
    assign cnt_inc    = (cnt_q == TMO_C) ? cnt_q : cnt_q + CW'(1);

    // Wired-OR of the read data of every device currently acknowledging.
    always_comb begin
        rd_or = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (devXfer[i]) begin
                rd_or = rd_or | devData[i*DW +: DW];
            end
        end
    end

    // Sequencer next-state, request latching, read capture and status flags.
    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        dev_d     = dev_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        scnt_d    = scnt_q;
        err_tmo_d = err_tmo_q;
        err_cfl_d = err_cfl_q;
        err_abt_d = err_abt_q;
        err_ill_d = err_ill_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    err_tmo_d = 1'b0;
                    err_cfl_d = 1'b0;
                    err_abt_d = 1'b0;
                    if (!func[2]) begin
                        func_d    = func;
                        dev_d     = devCode;
                        wdata_d   = wdata;
                        scnt_d    = '0;
                        err_ill_d = 1'b0;
                        state_d   = S_SETUP;
                    end else begin
                        // Reserved function: report it without touching the bus.
                        err_ill_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                end
            end
            S_SETUP: begin
                if (abort) begin
                    err_abt_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end else if (scnt_q >= SETUP_M1) begin
                    cnt_d   = '0;
                    state_d = S_DEMAND;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
            S_DEMAND: begin
                if (xfer_any) begin
                    // A responding device beats a coincident timeout; abort is still recorded.
                    if (func_q[0]) begin
                        rdata_d = rd_or;
                    end
                    err_cfl_d = xfer_multi;
                    if (abort) begin
                        err_abt_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (abort) begin
                    err_abt_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end else if (cnt_q >= TMO_M1) begin
                    err_tmo_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RELEASE: begin
                if (!xfer_any) begin
                    state_d = S_FINISH;
                end else if (cnt_q >= TMO_M1) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight transfer silently.
    always_ff @(posedge clk60 or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state_q   <= S_IDLE;
            func_q    <= '0;
            dev_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            scnt_q    <= '0;
            err_tmo_q <= 1'b0;
            err_cfl_q <= 1'b0;
            err_abt_q <= 1'b0;
            err_ill_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            dev_q     <= dev_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            scnt_q    <= scnt_d;
            err_tmo_q <= err_tmo_d;
            err_cfl_q <= err_cfl_d;
            err_abt_q <= err_abt_d;
            err_ill_q <= err_ill_d;
        end
    end

    // Bus outputs decode straight from state so reset clears them without waiting for a clock.
    assign on_bus        = (state_q == S_SETUP) || (state_q == S_DEMAND) || (state_q == S_RELEASE);
    assign ebusCS        = on_bus ? dev_q : '0;
    assign ebusFunc      = on_bus ? func_q : 3'd0;
    assign ebusDemand    = (state_q == S_DEMAND);
    assign ebusDataOutEn = on_bus && !func_q[0];
    assign ebusDataOut   = ebusDataOutEn ? wdata_q : '0;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FINISH);
    assign rdata         = rdata_q;
    assign errTimeout    = err_tmo_q;
    assign errConflict   = err_cfl_q;
    assign errAbort      = err_abt_q;
    assign errIllegal    = err_ill_q;

endmodule

// File: tb/tb_ebus_xfer.sv
// Testbench for ebus_xfer: transaction-level timeline model, per-cycle compare.
// Latency: open-loop stimulus, expected outputs derived per relative cycle.
// Backpressure: device acknowledges are scripted windows, aborts scripted cycles.
module tb_ebus_xfer;

    localparam int NDEV      = 8;
    localparam int DW        = 36;
    localparam int DEVW      = 7;
    localparam int SETUP_CYC = 1;
    localparam int TMO       = 4;

    logic                clk60 = 1'b0;
    logic                CROBAR_N;
    logic                req;
    logic [2:0]          func;
    logic [DEVW-1:0]     devCode;
    logic [DW-1:0]       wdata;
    logic                abort;
    logic                busy;
    logic                done;
    logic [DW-1:0]       rdata;
    logic                errTimeout, errConflict, errAbort, errIllegal;
    logic [DEVW-1:0]     ebusCS;
    logic [2:0]          ebusFunc;
    logic                ebusDemand;
    logic [DW-1:0]       ebusDataOut;
    logic                ebusDataOutEn;
    logic [NDEV-1:0]     devXfer;
    logic [NDEV*DW-1:0]  devData;
    logic [DW-1:0]       dev_data [NDEV];

    ebus_xfer #(
        .NDEV(NDEV), .DW(DW), .DEVW(DEVW), .SETUP_CYC(SETUP_CYC), .TMO(TMO)
    ) dut (
        .clk60(clk60), .CROBAR_N(CROBAR_N), .req(req), .func(func),
        .devCode(devCode), .wdata(wdata), .abort(abort), .busy(busy),
        .done(done), .rdata(rdata), .errTimeout(errTimeout),
        .errConflict(errConflict), .errAbort(errAbort), .errIllegal(errIllegal),
        .ebusCS(ebusCS), .ebusFunc(ebusFunc), .ebusDemand(ebusDemand),
        .ebusDataOut(ebusDataOut), .ebusDataOutEn(ebusDataOutEn),
        .devXfer(devXfer), .devData(devData)
    );

    always #5 clk60 = ~clk60;

    always_comb begin
        for (int i = 0; i < NDEV; i++) begin
            devData[i*DW +: DW] = dev_data[i];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected values for the current cycle, written by the stimulus task.
    bit              chk_en = 1'b0;
    bit              exp_chk_st = 1'b0;
    logic            exp_busy, exp_done, exp_dem, exp_en;
    logic [DEVW-1:0] exp_cs;
    logic [2:0]      exp_fn;
    logic [DW-1:0]   exp_dout;
    logic [DW-1:0]   exp_rdata = '0;
    logic            exp_tmo = 1'b0, exp_cfl = 1'b0, exp_abt = 1'b0, exp_ill = 1'b0;

    // Single compare process, mid-cycle.
    always @(negedge clk60) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("done", 64'(done), 64'(exp_done));
            chk("ebusDemand", 64'(ebusDemand), 64'(exp_dem));
            chk("ebusCS", 64'(ebusCS), 64'(exp_cs));
            chk("ebusFunc", 64'(ebusFunc), 64'(exp_fn));
            chk("ebusDataOutEn", 64'(ebusDataOutEn), 64'(exp_en));
            chk("ebusDataOut", 64'(ebusDataOut), 64'(exp_dout));
            if (exp_chk_st) begin
                chk("rdata", 64'(rdata), 64'(exp_rdata));
                chk("errTimeout", 64'(errTimeout), 64'(exp_tmo));
                chk("errConflict", 64'(errConflict), 64'(exp_cfl));
                chk("errAbort", 64'(errAbort), 64'(exp_abt));
                chk("errIllegal", 64'(errIllegal), 64'(exp_ill));
            end
        end
    end

    function automatic logic [NDEV-1:0] xfer_at(input int t, input int xs, input int xe,
                                                input logic [NDEV-1:0] m);
        return (t >= xs && t < xe) ? m : '0;
    endfunction

    function automatic logic [DW-1:0] or_data(input logic [NDEV-1:0] m);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (m[i]) v = v | dev_data[i];
        end
        return v;
    endfunction

    // One transaction. Cycle t is the cycle ending at edge t; req is sampled at edge 0.
    // Devices assert mask during cycles [xs, xe); abort is high in cycle ab (0 = never).
    task automatic run_xfer(input logic [2:0] fn, input logic [DEVW-1:0] dv,
                            input logic [DW-1:0] wd, input logic [NDEV-1:0] m,
                            input int xs, input int xe, input int ab, input bit hold,
                            output int fin);
        int ds, de, rs, re, c, r;
        logic [NDEV-1:0] mx;
        logic [DW-1:0] n_rd;
        logic n_tmo, n_cfl, n_abt, n_ill, on;
        n_rd  = exp_rdata;
        n_tmo = 1'b0; n_cfl = 1'b0; n_abt = 1'b0; n_ill = 1'b0;
        rs = 0;
        if (fn[2]) begin
            n_ill = 1'b1; fin = 1; ds = 1; de = 0; re = 0;
        end else begin
            if (ab >= 1 && ab <= SETUP_CYC) begin
                n_abt = 1'b1; ds = ab + 1; de = ab; rs = ab + 1;
            end else begin
                ds = SETUP_CYC + 1;
                c  = ds;
                while (1) begin
                    mx = xfer_at(c, xs, xe, m);
                    if (mx != '0) begin
                        if (fn[0]) n_rd = or_data(mx);
                        n_cfl = ($countones(mx) > 1);
                        if (ab == c) n_abt = 1'b1;
                        break;
                    end
                    if (ab == c) begin n_abt = 1'b1; break; end
                    if (c - ds + 1 == TMO) begin n_tmo = 1'b1; break; end
                    c++;
                end
                de = c; rs = c + 1;
            end
            r = rs;
            while (xfer_at(r, xs, xe, m) != '0) begin
                if (r - rs + 1 == TMO) begin n_tmo = 1'b1; break; end
                r++;
            end
            re = r; fin = r + 1;
        end
        for (int t = 0; t <= fin; t++) begin
            if (t > 0) begin
                @(posedge clk60); #1;
            end
            req     = (t == 0) || hold;
            func    = fn;
            devCode = dv;
            wdata   = wd;
            devXfer = xfer_at(t, xs, xe, m);
            abort   = (ab != 0) && (t == ab);
            if (t == fin) begin
                exp_rdata = n_rd; exp_tmo = n_tmo; exp_cfl = n_cfl;
                exp_abt = n_abt; exp_ill = n_ill;
            end
            on         = (t >= 1) && (t <= re);
            exp_busy   = (t >= 1);
            exp_done   = (t == fin);
            exp_dem    = (t >= ds) && (t <= de);
            exp_cs     = on ? dv : '0;
            exp_fn     = on ? fn : 3'd0;
            exp_en     = on && !fn[0];
            exp_dout   = exp_en ? wd : '0;
            exp_chk_st = (t == 0) || (t == fin);
            chk_en     = 1'b1;
        end
        @(posedge clk60); #1;
        req = 1'b0; devXfer = '0; abort = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_dem = 1'b0; exp_cs = '0;
        exp_fn = 3'd0; exp_en = 1'b0; exp_dout = '0; exp_chk_st = 1'b1;
    endtask

    initial begin
        int fin;
        logic [2:0] rfn;
        logic [NDEV-1:0] rm;
        int sel, xs, ab;
        CROBAR_N = 1'b1;
        req = 1'b0; func = 3'd0; devCode = '0; wdata = '0; abort = 1'b0; devXfer = '0;
        for (int i = 0; i < NDEV; i++) dev_data[i] = 36'({$urandom, $urandom});
        #1 CROBAR_N = 1'b0;
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_errs", 64'({errTimeout, errConflict, errAbort, errIllegal}), 64'd0);
        chk("reset_bus", 64'({ebusCS, ebusFunc, ebusDemand, ebusDataOutEn}), 64'd0);
        repeat (2) @(posedge clk60);
        #3 CROBAR_N = 1'b1;
        @(posedge clk60); #1;

        // DATAI from device 3: xfer cycles 3..4, done in cycle 6.
        dev_data[3] = 36'o123456701234;
        run_xfer(3'd3, 7'd3, '0, 8'h08, 3, 5, 0, 1'b0, fin);
        chk("t1_fin_cycle", 64'(fin), 64'd6);
        chk("t1_rdata", 64'(rdata), 64'o123456701234);
        chk("t1_errs", 64'({errTimeout, errConflict, errAbort, errIllegal}), 64'd0);

        // CONO to device 5: read data must be left alone.
        run_xfer(3'd0, 7'd5, 36'o777, 8'h20, 3, 4, 0, 1'b0, fin);
        chk("t2_rdata_kept", 64'(rdata), 64'o123456701234);

        // Nobody answers: 4 demand cycles, 1 release, done in cycle 7.
        run_xfer(3'd2, 7'd9, 36'o4242, 8'h00, 0, 0, 0, 1'b0, fin);
        chk("t3_fin_cycle", 64'(fin), 64'd7);
        chk("t3_timeout", 64'(errTimeout), 64'd1);

        // CONI with two devices answering together.
        dev_data[1] = 36'o700000000000;
        dev_data[2] = 36'o000000000017;
        run_xfer(3'd1, 7'd2, '0, 8'h06, 4, 6, 0, 1'b0, fin);
        chk("t4_rdata_or", 64'(rdata), 64'o700000000017);
        chk("t4_conflict", 64'(errConflict), 64'd1);

        // Abort in the second demand cycle.
        run_xfer(3'd3, 7'd4, '0, 8'h00, 0, 0, 3, 1'b0, fin);
        chk("t5_fin_cycle", 64'(fin), 64'd5);
        chk("t5_abort", 64'(errAbort), 64'd1);
        chk("t5_no_timeout", 64'(errTimeout), 64'd0);

        // Reserved function.
        run_xfer(3'd6, 7'd1, '0, 8'hFF, 1, 4, 0, 1'b0, fin);
        chk("t6_fin_cycle", 64'(fin), 64'd1);
        chk("t6_illegal", 64'(errIllegal), 64'd1);

        // req held through FINISH, then accepted in the following idle cycle.
        run_xfer(3'd3, 7'd3, '0, 8'h08, 3, 4, 0, 1'b1, fin);
        run_xfer(3'd2, 7'd6, 36'o55, 8'h40, 3, 4, 0, 1'b0, fin);

        // Reset in the middle of DEMAND.
        chk_en = 1'b0;
        req = 1'b1; func = 3'd3; devCode = 7'd3;
        @(posedge clk60); #1 req = 1'b0;
        @(posedge clk60); #2;
        chk("rst_pre_demand", 64'(ebusDemand), 64'd1);
        CROBAR_N = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_errs", 64'({errTimeout, errConflict, errAbort, errIllegal}), 64'd0);
        chk("rst_bus", 64'({ebusCS, ebusFunc, ebusDemand, ebusDataOutEn}), 64'd0);
        repeat (3) begin
            @(negedge clk60);
            chk("rst_no_done", 64'(done), 64'd0);
        end
        @(posedge clk60); #3 CROBAR_N = 1'b1;
        @(posedge clk60); #1;
        exp_rdata = '0; exp_tmo = 1'b0; exp_cfl = 1'b0; exp_abt = 1'b0; exp_ill = 1'b0;
        run_xfer(3'd1, 7'd5, '0, 8'h20, 2, 3, 0, 1'b0, fin);

        // Randomized transactions.
        repeat (150) begin
            for (int i = 0; i < NDEV; i++) dev_data[i] = 36'({$urandom, $urandom});
            rfn = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel == 0) rm = '0;
            else if (sel <= 2) rm = NDEV'($urandom_range(0, 255));
            else rm = NDEV'(1) << $urandom_range(0, NDEV - 1);
            xs = $urandom_range(1, 8);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
            run_xfer(rfn, 7'($urandom_range(0, 127)), 36'({$urandom, $urandom}), rm,
                     xs, xs + $urandom_range(1, 7), ab, ($urandom_range(0, 7) == 0), fin);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
